// File: rtl/ravan_top_if.sv
// Data/key bus for the ravan cipher engine; no flow control, sampled every cycle.
// Master drives mode, plaintext and key; slave returns the registered result.
interface ravan_top_if;
   logic         enc_op_sel;
   logic [63:0]  data_in;
   logic [511:0] key;
   logic [63:0]  data_out;

   modport master (output enc_op_sel, output data_in, output key, input data_out);
   modport slave  (input enc_op_sel, input data_in, input key, output data_out);
endinterface

// File: rtl/ravan_top.sv
// 64-bit ARX block cipher with 512-bit folded key and on-chip ciphertext loopback for decrypt.
// Latency 1 clock from sampled inputs to data_out; runs every cycle, no backpressure.
module ravan_top #(
   parameter int ROUNDS = 8,
   parameter int ROT    = 13
) (
   input  logic        clk,
   input  logic        rst,
   ravan_top_if.slave  bus
);

   function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned s);
      logic [6:0] a;
      a = 7'(s % 64);
      if (a == 7'd0) return x;
      return (x << a) | (x >> (7'd64 - a));
   endfunction

   function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned s);
      return rotl64(x, (64 - (s % 64)) % 64);
   endfunction

   logic [63:0]              w_k;
   logic [ROUNDS-1:0][63:0]  w_rk;
   logic [ROUNDS:0][63:0]    w_enc;
   logic [ROUNDS:0][63:0]    w_dec;
   logic [63:0]              r_data_out;
   logic [63:0]              r_cipher_hold;

   always_comb begin
      w_k = '0;
      for (int i = 0; i < 8; i++) begin
         w_k = w_k ^ bus.key[64*i +: 64];
      end
   end

   always_comb begin
      w_rk = '0;
      for (int i = 0; i < ROUNDS; i++) begin
         w_rk[i] = rotl64(w_k, (8 * i) % 64) ^ 64'(i);
      end
   end

   always_comb begin
      w_enc    = '0;
      w_enc[0] = bus.data_in;
      for (int i = 0; i < ROUNDS; i++) begin
         w_enc[i+1] = rotl64(w_enc[i] ^ w_rk[i], ROT) + w_rk[i];
      end
   end

   // Decrypt chain is indexed top-down so w_dec[0] is the recovered plaintext.
   always_comb begin
      w_dec         = '0;
      w_dec[ROUNDS] = r_cipher_hold;
      for (int i = ROUNDS - 1; i >= 0; i--) begin
         w_dec[i] = rotr64(w_dec[i+1] - w_rk[i], ROT) ^ w_rk[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data_out    <= '0;
         r_cipher_hold <= '0;
      end else if (bus.enc_op_sel) begin
         r_data_out    <= w_enc[ROUNDS];
         r_cipher_hold <= w_enc[ROUNDS];
      end else begin
         r_data_out    <= w_dec[0];
      end
   end

   assign bus.data_out = r_data_out;

endmodule

// File: tb/tb_ravan_top.sv
// Directed and random self-checking bench for ravan_top against an independent E/D model.
module tb_ravan_top;
   localparam int ROUNDS = 8;
   localparam int ROT    = 13;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   ravan_top_if u_if();

   ravan_top #(.ROUNDS(ROUNDS), .ROT(ROT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] m_rotl(input logic [63:0] x, input int s);
      logic [127:0] d;
      d = {x, x} << (s % 64);
      return d[127:64];
   endfunction

   function automatic logic [63:0] m_rotr(input logic [63:0] x, input int s);
      logic [127:0] d;
      d = {x, x} >> (s % 64);
      return d[63:0];
   endfunction

   function automatic logic [63:0] m_rk(input logic [511:0] k, input int i);
      logic [63:0] f;
      f = 64'h0;
      for (int w = 0; w < 8; w++) f ^= k[64*w +: 64];
      return m_rotl(f, (8 * i) % 64) ^ 64'(i);
   endfunction

   function automatic logic [63:0] m_enc(input logic [63:0] x, input logic [511:0] k);
      logic [63:0] r;
      for (int i = 0; i < ROUNDS; i++) begin
         r = m_rk(k, i);
         x = m_rotl(x ^ r, ROT) + r;
      end
      return x;
   endfunction

   function automatic logic [63:0] m_dec(input logic [63:0] y, input logic [511:0] k);
      logic [63:0] r;
      for (int i = ROUNDS - 1; i >= 0; i--) begin
         r = m_rk(k, i);
         y = m_rotr(y - r, ROT) ^ r;
      end
      return y;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [511:0] STD_KEY = 512'hA5A5A5A5A5A5A5A5_FF00FF00FF00FF00_123456789ABCDEF0123456789ABCDEF0_99887766554433221100FFEEDDCCBBAA_00112233445566778899AABBCCDDEEFD;
   localparam logic [63:0]  STD_PT  = 64'h1234_5678_ABCD_EF01;

   logic [63:0]  vecs [8];
   logic [63:0]  pt;
   logic [511:0] rk_key;
   int           rnd_err_before;

   initial begin
      n_checks = 0;
      n_errors = 0;
      vecs[0] = 64'h0;               vecs[1] = 64'hFFFF_FFFF_FFFF_FFFF;
      vecs[2] = 64'h8000_0000_0000_0001; vecs[3] = 64'h0123_4567_89AB_CDEF;
      vecs[4] = 64'hDEAD_BEEF_CAFE_F00D; vecs[5] = 64'h0000_0000_0000_0001;
      vecs[6] = 64'hAAAA_5555_AAAA_5555; vecs[7] = 64'h7FFF_FFFF_FFFF_FFFE;

      // Reset with clock idle: output clears before any edge.
      rst = 1'b1;
      u_if.enc_op_sel = 1'b1;
      u_if.data_in    = 64'h0;
      u_if.key        = '0;
      #3;
      chk("reset_out", u_if.data_out, 64'h0);
      rst = 1'b0;

      // Zero key: every round key is just the round index.
      tick();
      chk("enc_zero_key", u_if.data_out, m_enc(64'h0, '0));
      u_if.data_in = 64'h1;
      tick();
      chk("enc_zero_key_one", u_if.data_out, m_enc(64'h1, '0));

      // Standard vector round trip.
      u_if.key     = STD_KEY;
      u_if.data_in = STD_PT;
      repeat (10) tick();
      chk("std_ct_differs", {63'h0, u_if.data_out != STD_PT}, 64'h1);
      chk("std_ct_model", u_if.data_out, m_enc(STD_PT, STD_KEY));
      u_if.enc_op_sel = 1'b0;
      repeat (10) tick();
      chk("std_pt_recovered", u_if.data_out, STD_PT);

      // data_in is ignored while decrypting.
      u_if.data_in = 64'hDEADBEEF_00000000;
      repeat (3) tick();
      chk("dec_hold", u_if.data_out, STD_PT);

      // One-cycle latency with data_in changing every cycle.
      u_if.enc_op_sel = 1'b1;
      for (int j = 0; j < 8; j++) begin
         u_if.data_in = vecs[j];
         tick();
         chk($sformatf("latency_%0d", j), u_if.data_out, m_enc(vecs[j], STD_KEY));
      end

      // Mode change at next edge, then async reset between edges.
      u_if.enc_op_sel = 1'b0;
      tick();
      chk("dec_last_vec", u_if.data_out, vecs[7]);
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset_mid", u_if.data_out, 64'h0);
      rst = 1'b0;
      tick();
      chk("dec_after_reset", u_if.data_out, m_dec(64'h0, STD_KEY));

      // Random key/plaintext round trips.
      rnd_err_before = n_errors;
      for (int n = 0; n < 1000; n++) begin
         for (int w = 0; w < 16; w++) rk_key[32*w +: 32] = $urandom();
         pt = {$urandom(), $urandom()};
         u_if.key        = rk_key;
         u_if.data_in    = pt;
         u_if.enc_op_sel = 1'b1;
         tick();
         chk("rnd_ct", u_if.data_out, m_enc(pt, rk_key));
         u_if.enc_op_sel = 1'b0;
         u_if.data_in    = ~pt;
         tick();
         chk("rnd_pt", u_if.data_out, pt);
         if (n_errors - rnd_err_before > 10) break;
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ravan_top.md
Name: ravan_top

Overview:
- 64-bit block cipher engine with a 512-bit master key.
- The 512-bit key is folded to a 64-bit core key, which is expanded into per-round keys.
- Data passes through an unrolled add-rotate-xor round network with a registered output.
- Encrypt mode captures its ciphertext into an internal hold register. Decrypt mode decrypts that held ciphertext (loopback), so encrypt-then-decrypt round-trips on chip.

Parameters:
- ROUNDS, 8, number of unrolled rounds (1..16).
- ROT, 13, left-rotate amount per round (1..63).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- enc_op_sel  input  1  mode select: 1 = encrypt, 0 = decrypt.
- data_in  input  64  plaintext block; used only in encrypt mode.
- key  input  512  master key; must be held stable while operating.
- data_out  output  64  registered result (ciphertext or plaintext).

Behaviour:
- Interface: one clock, clk. rst is asynchronous and active-high.
- Key reduction (combinational): K = XOR of the eight 64-bit words key[64i+63:64i], i = 0..7.
- Round keys (combinational): rk[i] = rotl64(K, 8*i mod 64) XOR zero-extended i, for i = 0..ROUNDS-1.
- Encrypt function E(x): for i = 0..ROUNDS-1, x = (rotl64(x XOR rk[i], ROT) + rk[i]) mod 2^64.
- Decrypt function D(y): for i = ROUNDS-1 down to 0, y = rotr64((y - rk[i]) mod 2^64, ROT) XOR rk[i].
- D(E(x)) = x is required for every x and every key.
- Registers: data_out_r and cipher_hold, both 64 bits.
- Reset: while rst = 1, data_out = 0 and cipher_hold = 0 immediately, with no clock needed.
- Encrypt mode (enc_op_sel = 1), at each rising edge:
  - cipher_hold <= E(data_in)
  - data_out <= E(data_in)
- Decrypt mode (enc_op_sel = 0), at each rising edge:
  - data_out <= D(cipher_hold)
  - cipher_hold keeps its value
  - data_in is ignored
- Latency: 1 clock from sampled inputs to data_out. There is no handshake; the block runs every cycle.
- Mode change takes effect at the first rising edge after enc_op_sel changes.
- Key change takes effect at the next edge. cipher_hold is not re-encrypted, so decrypting a block held under an old key with a new key produces garbage by design.
- Decrypt after reset with no prior encrypt: data_out = D(0) under the current key.
- rst asserted mid-stream clears both registers. The first edge after rst deasserts behaves per the current mode.
- No X propagation: every register has a reset value.
- All arithmetic wraps mod 2^64. Rotations use a constant amount (no barrel shifter).

Test Plan:
- Reset: assert rst with clk idle -> data_out == 64'h0 immediately. Release rst and encrypt with key = 0, data_in = 0, ROUNDS = 8 -> every rk[i] = i; check data_out against the E(x) reference model.
- Round trip, standard vector:
  - key = 512'hA5A5A5A5A5A5A5A5_FF00FF00FF00FF00_123456789ABCDEF0123456789ABCDEF0_99887766554433221100FFEEDDCCBBAA_00112233445566778899AABBCCDDEEFD
  - data_in = 64'h1234_5678_ABCD_EF01, encrypt 10 cycles -> data_out != data_in and equals the model value.
  - Set enc_op_sel = 0, leave data_in unchanged, run 10 cycles -> data_out == 64'h1234_5678_ABCD_EF01.
- Latency: toggle data_in every cycle in encrypt mode -> data_out each cycle equals E(data_in from the previous edge).
- Hold: in decrypt mode, change data_in to 64'hDEADBEEF_00000000 -> data_out stays at the recovered plaintext.
- Async reset mid-stream: pulse rst between edges during decrypt -> data_out == 0 at once. The next decrypt edge gives D(0).
- Random: 1000 random key/plaintext pairs, each encrypted one cycle then decrypted one cycle -> plaintext recovered every time, and ciphertext matches the model.
